// File: rtl/balanced_5b_encoder.sv
// Purpose : byte -> 10-bit balanced symbol encoder (two 5-bit halves, 3+2 ones), with periodic sync insertion.
// Latency : one cycle from byte acceptance (v_i & ready_o) to data_o/v_o.
// Backpr. : ready_o drops on the sync slot and while disabled; the source must hold its byte until accepted.
//
// Ports:
//   clk_i        - clock, all state on rising edge
//   reset_i      - asynchronous active-high reset
//   enable_i     - line enable; when low the line idles and the sync counter freezes
//   data_i/v_i   - byte to encode and its valid
//   ready_o      - byte is consumed on a cycle where v_i and ready_o are both high
//   data_o       - registered symbol {upper[9:5], lower[4:0]}
//   v_o          - data_o carries an encoded byte
//   sync_o       - data_o is the sync symbol
//   err_o        - one-cycle pulse: the accepted byte had no codeword
//   err_count_o  - saturating count of unencodable bytes
module balanced_5b_encoder #(
  parameter int unsigned SYNC_PERIOD_P = 64
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic [7:0] data_i,
  input  logic       v_i,
  output logic       ready_o,
  output logic [9:0] data_o,
  output logic       v_o,
  output logic       sync_o,
  output logic       err_o,
  output logic [7:0] err_count_o
);

  localparam logic [8:0] CNT_LAST = 9'(SYNC_PERIOD_P - 1);
  localparam logic [9:0] IDLE_SYM = 10'h29A;  // {H2[8],H3[8]}
  localparam logic [9:0] SYNC_SYM = 10'h29C;  // {H2[8],H3[9]}

  // Three-ones half codes.
  function automatic logic [4:0] h3(input logic [3:0] idx);
    logic [4:0] c;
    case (idx)
      4'd0:    c = 5'b00111;
      4'd1:    c = 5'b01011;
      4'd2:    c = 5'b01101;
      4'd3:    c = 5'b01110;
      4'd4:    c = 5'b10011;
      4'd5:    c = 5'b10101;
      4'd6:    c = 5'b10110;
      4'd7:    c = 5'b11001;
      4'd8:    c = 5'b11010;
      default: c = 5'b11100;
    endcase
    return c;
  endfunction

  // Two-ones half codes.
  function automatic logic [4:0] h2(input logic [3:0] idx);
    logic [4:0] c;
    case (idx)
      4'd0:    c = 5'b00011;
      4'd1:    c = 5'b00101;
      4'd2:    c = 5'b00110;
      4'd3:    c = 5'b01010;
      4'd4:    c = 5'b01100;
      4'd5:    c = 5'b01001;
      4'd6:    c = 5'b10001;
      4'd7:    c = 5'b10010;
      4'd8:    c = 5'b10100;
      default: c = 5'b11000;
    endcase
    return c;
  endfunction

  // Returns {encodable, symbol}. Indices 8/9 are reached as {3'b100, bit}.
  function automatic logic [10:0] encode(input logic [7:0] b);
    logic [10:0] r;
    casez (b)
      8'b00??????: r = {1'b1, h3({1'b0, b[5:3]}), h2({1'b0, b[2:0]})};
      8'b01??????: r = {1'b1, h2({1'b0, b[5:3]}), h3({1'b0, b[2:0]})};
      8'b1000????: r = {1'b1, h3({3'b100, b[3]}), h2({1'b0, b[2:0]})};
      8'b1001????: r = {1'b1, h2({3'b100, b[3]}), h3({1'b0, b[2:0]})};
      8'b1010????: r = {1'b1, h3({1'b0, b[2:0]}), h2({3'b100, b[3]})};
      8'b1011????: r = {1'b1, h2({1'b0, b[2:0]}), h3({3'b100, b[3]})};
      8'b111100??: r = {1'b1, h3({3'b100, b[1]}), h2({3'b100, b[0]})};
      8'b1111011?: r = {1'b1, h2(4'd9), h3({3'b100, b[0]})};
      default:     r = {1'b0, IDLE_SYM};
    endcase
    return r;
  endfunction

  logic [9:0]  data_q, data_d;
  logic        v_q, v_d;
  logic        sync_q, sync_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        sync_due;
  logic        accept;
  logic [10:0] enc;

  assign sync_due = (cnt_q == CNT_LAST);
  assign ready_o  = enable_i & ~sync_due;
  assign accept   = v_i & ready_o;
  assign enc      = encode(data_i);

  always_comb begin
    data_d    = IDLE_SYM;
    v_d       = 1'b0;
    sync_d    = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    if (enable_i) begin
      cnt_d = cnt_q + 9'd1;
      if (sync_due) begin
        data_d = SYNC_SYM;
        sync_d = 1'b1;
        cnt_d  = 9'd0;
      end else if (accept) begin
        if (enc[10]) begin
          data_d = enc[9:0];
          v_d    = 1'b1;
        end else begin
          // Unencodable byte: consumed, line idles, error flagged.
          err_d = 1'b1;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
    end
  end

  // Counter resets to the last slot so the first enabled symbol is sync.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q    <= IDLE_SYM;
      v_q       <= 1'b0;
      sync_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
      cnt_q     <= CNT_LAST;
    end else begin
      data_q    <= data_d;
      v_q       <= v_d;
      sync_q    <= sync_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign data_o      = data_q;
  assign v_o         = v_q;
  assign sync_o      = sync_q;
  assign err_o       = err_q;
  assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_balanced_5b_encoder.sv
// Purpose : scoreboard bench for balanced_5b_encoder with a table-based reference encoder/decoder.
// Latency : model predicts each registered symbol one cycle after the inputs it saw.
// Backpr. : source holds an offered byte until ready_o accepts it.
module tb_balanced_5b_encoder;

  localparam int P = 4;
  localparam logic [9:0] IDLE = 10'h29A;
  localparam logic [9:0] SYNC = 10'h29C;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       enable_i = 1'b0;
  logic       v_i = 1'b0;
  logic [7:0] data_i = 8'd0;
  logic       ready_o;
  logic [9:0] data_o;
  logic       v_o;
  logic       sync_o;
  logic       err_o;
  logic [7:0] err_count_o;

  balanced_5b_encoder #(.SYNC_PERIOD_P(P)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .enable_i    (enable_i),
    .data_i      (data_i),
    .v_i         (v_i),
    .ready_o     (ready_o),
    .data_o      (data_o),
    .v_o         (v_o),
    .sync_o      (sync_o),
    .err_o       (err_o),
    .err_count_o (err_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [4:0] H3 [10] = '{5'b00111, 5'b01011, 5'b01101, 5'b01110, 5'b10011,
                          5'b10101, 5'b10110, 5'b11001, 5'b11010, 5'b11100};
  logic [4:0] H2 [10] = '{5'b00011, 5'b00101, 5'b00110, 5'b01010, 5'b01100,
                          5'b01001, 5'b10001, 5'b10010, 5'b10100, 5'b11000};

  typedef struct {
    logic [9:0] d;
    logic       v;
    logic       s;
    logic       e;
    logic [7:0] ec;
    logic [7:0] b;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] src_q[$];
  int mcnt = P - 1;
  int merr = 0;

  // Reference encoder written from the byte ranges.
  function automatic bit ref_encode(input int b, output logic [9:0] sym);
    int hi, lo, z;
    hi = (b / 8) % 8;
    lo = b % 8;
    z  = (b / 8) % 2;
    sym = IDLE;
    if (b < 'h40)       sym = {H3[hi], H2[lo]};
    else if (b < 'h80)  sym = {H2[hi], H3[lo]};
    else if (b < 'h90)  sym = {H3[8 + z], H2[lo]};
    else if (b < 'hA0)  sym = {H2[8 + z], H3[lo]};
    else if (b < 'hB0)  sym = {H3[lo], H2[8 + z]};
    else if (b < 'hC0)  sym = {H2[lo], H3[8 + z]};
    else if (b < 'hF0)  return 1'b0;
    else if (b < 'hF4)  sym = {H3[8 + (b / 2) % 2], H2[8 + b % 2]};
    else if (b == 'hF6 || b == 'hF7) sym = {H2[9], H3[8 + b % 2]};
    else return 1'b0;
    return 1'b1;
  endfunction

  function automatic int idx_in(input logic [4:0] c, input bit is_h3);
    for (int i = 0; i < 10; i++) begin
      if ((is_h3 ? H3[i] : H2[i]) == c) return i;
    end
    return -1;
  endfunction

  // Inverse tables: symbol -> byte, -1 if not a data codeword.
  function automatic int ref_decode(input logic [9:0] s);
    int u3, u2, l3, l2;
    u3 = idx_in(s[9:5], 1'b1);
    u2 = idx_in(s[9:5], 1'b0);
    l3 = idx_in(s[4:0], 1'b1);
    l2 = idx_in(s[4:0], 1'b0);
    if (u3 >= 0 && l2 >= 0) begin
      if (u3 < 8 && l2 < 8) return u3 * 8 + l2;
      if (l2 < 8)           return 'h80 + (u3 - 8) * 8 + l2;
      if (u3 < 8)           return 'hA0 + (l2 - 8) * 8 + u3;
      return 'hF0 + (u3 - 8) * 2 + (l2 - 8);
    end
    if (u2 >= 0 && l3 >= 0) begin
      if (u2 < 8 && l3 < 8) return 'h40 + u2 * 8 + l3;
      if (l3 < 8)           return 'h90 + (u2 - 8) * 8 + l3;
      if (u2 < 8)           return 'hB0 + (l3 - 8) * 8 + u2;
      if (u2 == 9)          return 'hF6 + (l3 - 8);
    end
    return -1;
  endfunction

  // Reference model: one expected symbol per clock out of reset.
  always @(posedge clk) begin
    exp_t e;
    logic [9:0] sym;
    if (!reset_i) begin
      e.d = IDLE; e.v = 1'b0; e.s = 1'b0; e.e = 1'b0; e.b = 8'd0;
      if (enable_i) begin
        if (mcnt == P - 1) begin
          e.d = SYNC; e.s = 1'b1; mcnt = 0;
        end else begin
          if (v_i) begin
            if (ref_encode(int'(data_i), sym)) begin
              e.d = sym; e.v = 1'b1; e.b = data_i;
            end else begin
              e.e = 1'b1;
              if (merr < 255) merr++;
            end
          end
          mcnt++;
        end
      end
      e.ec = 8'(merr);
      exp_q.push_back(e);
    end
  end

  // Monitor: pops one expectation per symbol and checks it.
  always @(negedge clk) begin
    exp_t e;
    int dec;
    if (reset_i) begin
      checks++;
      if ({data_o, v_o, sync_o, err_o, err_count_o} !== {IDLE, 3'b000, 8'd0}) begin
        errors++;
        $display("FAIL reset_hold t=%0t got d=%h v%b s%b e%b ec=%0d", $time, data_o, v_o, sync_o, err_o, err_count_o);
      end
    end else if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_underflow t=%0t got d=%h expected an entry", $time, data_o);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({data_o, v_o, sync_o, err_o, err_count_o} !== {e.d, e.v, e.s, e.e, e.ec}) begin
        errors++;
        $display("FAIL symbol t=%0t got d=%h v%b s%b e%b ec=%0d exp d=%h v%b s%b e%b ec=%0d",
                 $time, data_o, v_o, sync_o, err_o, err_count_o, e.d, e.v, e.s, e.e, e.ec);
      end
      checks++;
      if ($countones(data_o) != 5) begin
        errors++;
        $display("FAIL popcount t=%0t got %0d (d=%h) exp 5", $time, $countones(data_o), data_o);
      end
      if (e.v) begin
        dec = ref_decode(data_o);
        checks++;
        if (dec != int'(e.b)) begin
          errors++;
          $display("FAIL decode t=%0t got %0d exp %0d", $time, dec, e.b);
        end
      end
    end
  end

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h exp %0h", name, $time, got, exp);
    end
  endtask

  // One cycle of stimulus; ready_o checked against the model's slot position.
  task automatic step(input bit en, input bit v, input logic [7:0] d, output bit acc);
    @(negedge clk);
    enable_i = en; v_i = v; data_i = d;
    #1;
    check_val("ready", int'(ready_o), int'(en && (mcnt != P - 1)));
    acc = v && ready_o;
  endtask

  // Offer src_q bytes; an offered byte stays valid until accepted.
  task automatic send_all(input int vpct, input int enpct, input int budget, input bit must_drain);
    int n;
    bit acc, offered, v, en;
    n = 0; offered = 1'b0;
    while (src_q.size() > 0) begin
      if (n >= budget) begin
        if (must_drain) begin
          checks++; errors++;
          $display("FAIL send_timeout left=%0d exp 0", src_q.size());
        end
        src_q.delete();
        break;
      end
      v  = offered || ($urandom_range(0, 99) < vpct);
      en = ($urandom_range(0, 99) < enpct);
      step(en, v, v ? src_q[0] : 8'($urandom), acc);
      if (acc) void'(src_q.pop_front());
      offered = v && !acc;
      n++;
    end
  endtask

  task automatic idle_cycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, acc);
  endtask

  task automatic reset_async();
    @(posedge clk);
    #3 reset_i = 1'b1;
    exp_q.delete(); mcnt = P - 1; merr = 0;
    #1;
    check_val("async_reset_out", int'({data_o, v_o, sync_o, err_o, err_count_o}), int'({IDLE, 3'b000, 8'd0}));
    check_val("async_reset_rdy", int'(ready_o), 0);
    v_i = 1'b0; enable_i = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset_i = 1'b0;
  endtask

  initial begin
    bit acc;
    int r;
    // Reset hold with enable high: ready must stay low.
    enable_i = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_val("ready_in_reset", int'(ready_o), 0);
    #1 reset_i = 1'b0;

    // Idle line: sync every P symbols.
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b0, 8'h00, acc);
      check_val("idle_pattern", int'(data_o), int'((k % P == 0) ? SYNC : IDLE));
    end

    // Directed codewords, back-to-back, crossing sync slots.
    src_q = '{8'h00, 8'h45, 8'h80, 8'hF0, 8'hF7};
    send_all(100, 100, 40, 1'b1);
    idle_cycles(3);

    // Single unencodable byte.
    src_q.push_back(8'hC5);
    send_all(100, 100, 20, 1'b1);
    idle_cycles(2);
    check_val("err_count_one", int'(err_count_o), 1);

    // 300 unencodable bytes saturate the counter.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 57);
      if (r < 48)      src_q.push_back(8'(8'hC0 + r));
      else if (r < 50) src_q.push_back(8'(8'hF4 + r - 48));
      else             src_q.push_back(8'(8'hF8 + r - 50));
    end
    send_all(100, 100, 1000, 1'b1);
    idle_cycles(2);
    check_val("err_count_sat", int'(err_count_o), 255);

    // Exhaustive sweep with random valid gaps.
    for (int b = 0; b < 256; b++) src_q.push_back(8'(b));
    send_all(80, 100, 2000, 1'b1);

    // Enable dropped mid-interval with a byte waiting.
    idle_cycles(2);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'h12, acc);
      check_val("disabled_accept", int'(acc), 0);
    end
    src_q.push_back(8'h12);
    send_all(100, 100, 20, 1'b1);
    idle_cycles(6);

    // Random traffic with random enable, then reset mid-stream.
    for (int i = 0; i < 200; i++) src_q.push_back(8'($urandom));
    send_all(70, 85, 2000, 1'b1);
    for (int i = 0; i < 30; i++) src_q.push_back(8'($urandom_range(0, 'hBF)));
    send_all(100, 100, 9, 1'b0);
    reset_async();
    step(1'b1, 1'b0, 8'h00, acc);
    check_val("first_after_reset", int'({data_o, sync_o}), int'({SYNC, 1'b1}));
    for (int i = 0; i < 40; i++) src_q.push_back(8'($urandom));
    send_all(75, 90, 500, 1'b1);
    idle_cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout t=%0t exp finish before limit", $time);
    $fatal(1, "timeout");
  end

endmodule
